location_scan_scheduler: RTL

- Sequences and shares the single ultrasound location calculator between three requesters: the main rover-control FSM (port A), the display/debug path (port B) and an internal periodic timer.
- Each request is latched, coalesced into one measurement, and delivered with a per-requester acknowledge.
- A watchdog detects a hung calculator, pulses its reset, retries, and reports an error once retries are exhausted.

---
 rtl/location_scan_scheduler_if.sv | 30 +++
 rtl/location_scan_scheduler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/location_scan_scheduler_if.sv
// Bundles the requester, calculator and status signals of the location scan scheduler.
// The scheduler uses the slave modport; the environment driving it uses master.
interface location_scan_scheduler_if;
  logic        enable;
  logic        req_a;
  logic        req_b;
  logic        calc_done;
  logic [11:0] calc_location;
  logic        calc_start;
  logic        calc_reset;
  logic [11:0] location;
  logic        location_valid;
  logic        new_location;
  logic        ack_a;
  logic        ack_b;
  logic        scan_error;
  logic [2:0]  state;

  modport slave (
    input  enable, req_a, req_b, calc_done, calc_location,
    output calc_start, calc_reset, location, location_valid, new_location,
           ack_a, ack_b, scan_error, state
  );

  modport master (
    output enable, req_a, req_b, calc_done, calc_location,
    input  calc_start, calc_reset, location, location_valid, new_location,
           ack_a, ack_b, scan_error, state
  );
endinterface

// File: rtl/location_scan_scheduler.sv
// Shares one ultrasound location calculator between rover control (A), display (B) and a
// periodic timer; coalesces requests, guards the calculator with a watchdog and retries.
//
// Handshake: req_a/req_b are single-cycle strobes that latch a pending bit; each latched
// request is answered by exactly one single-cycle ack (with scan_error when it failed).
module location_scan_scheduler #(
  parameter int SCAN_PERIOD     = 6750000,
  parameter int WATCHDOG_CYCLES = 108000000,
  parameter int RESET_HOLD      = 16,
  parameter int MAX_RETRIES     = 2
) (
  input logic                       clock,
  input logic                       reset,
  location_scan_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_BUSY    = 3'd2,
    S_DELIVER = 3'd3,
    S_RECOVER = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  localparam logic [22:0] PERIOD_M1 = 23'(SCAN_PERIOD - 1);
  localparam logic [26:0] WD_M1     = 27'(WATCHDOG_CYCLES - 1);
  localparam logic [4:0]  HOLD      = 5'(RESET_HOLD);
  localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRIES);

  state_t      r_state;
  state_t      w_next;
  logic        r_pend_a, r_pend_b, r_pend_p;
  logic [1:0]  r_served;
  logic [22:0] r_timer;
  logic [26:0] r_wd;
  logic [4:0]  r_rec;
  logic [1:0]  r_retry;
  logic        r_done_s, r_done_d;
  logic [11:0] r_location;
  logic        r_valid;

  logic w_tick, w_any_pend, w_take, w_done_rise, w_wd_expire, w_rec_end;
  logic w_calc_start, w_calc_reset, w_new_location, w_ack_a, w_ack_b, w_scan_error;

  // calc_done passes one register stage before edge detection, so the edge is seen in BUSY
  // one cycle after it arrives and the ack follows two cycles after the rising edge.
  assign w_done_rise = r_done_s & ~r_done_d;
  assign w_tick      = bus.enable && (r_timer == PERIOD_M1);
  assign w_any_pend  = r_pend_a | r_pend_b | r_pend_p;
  assign w_take      = (r_state == S_IDLE) && w_any_pend;
  assign w_wd_expire = (r_wd == WD_M1);
  assign w_rec_end   = (r_rec == HOLD);

  always_comb begin
    w_next         = r_state;
    w_calc_start   = 1'b0;
    w_calc_reset   = 1'b0;
    w_new_location = 1'b0;
    w_ack_a        = 1'b0;
    w_ack_b        = 1'b0;
    w_scan_error   = 1'b0;
    case (r_state)
      S_IDLE: if (w_any_pend) w_next = S_START;
      S_START: begin
        w_calc_start = 1'b1;
        w_next       = S_BUSY;
      end
      S_BUSY: begin
        if (w_done_rise)      w_next = S_DELIVER;
        else if (w_wd_expire) w_next = S_RECOVER;
      end
      S_DELIVER: begin
        w_new_location = 1'b1;
        w_ack_a        = r_served[0];
        w_ack_b        = r_served[1];
        w_next         = S_IDLE;
      end
      S_RECOVER: begin
        w_calc_reset = (r_rec < HOLD);
        if (w_rec_end) w_next = (r_retry < RETRY_MAX) ? S_START : S_ERROR;
      end
      S_ERROR: begin
        w_scan_error = 1'b1;
        w_ack_a      = r_served[0];
        w_ack_b      = r_served[1];
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pend_a   <= 1'b0;
      r_pend_b   <= 1'b0;
      r_pend_p   <= 1'b0;
      r_served   <= '0;
      r_timer    <= '0;
      r_wd       <= '0;
      r_rec      <= '0;
      r_retry    <= '0;
      r_done_s   <= 1'b0;
      r_done_d   <= 1'b0;
      r_location <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_done_s <= bus.calc_done;
      r_done_d <= r_done_s;

      if (!bus.enable)     r_timer <= '0;
      else if (w_tick)     r_timer <= '0;
      else                 r_timer <= r_timer + 23'd1;

      // A new request in the same cycle as the clear keeps its bit for the next scan.
      r_pend_a <= bus.req_a | (r_pend_a & ~w_take);
      r_pend_b <= bus.req_b | (r_pend_b & ~w_take);
      r_pend_p <= w_tick    | (r_pend_p & ~w_take);

      if (w_take) begin
        r_served <= {r_pend_b, r_pend_a};
        r_retry  <= '0;
      end

      if (r_state == S_START) r_wd <= '0;

      if (r_state == S_BUSY) begin
        r_wd <= r_wd + 27'd1;
        // Capture on the edge so location is already updated while new_location is high.
        if (w_done_rise) begin
          r_location <= bus.calc_location;
          r_valid    <= 1'b1;
        end else if (w_wd_expire) begin
          r_rec <= '0;
        end
      end

      if (r_state == S_RECOVER) begin
        r_rec <= r_rec + 5'd1;
        if (w_rec_end && (r_retry < RETRY_MAX)) r_retry <= r_retry + 2'd1;
      end
    end
  end

  assign bus.calc_start     = w_calc_start;
  assign bus.calc_reset     = w_calc_reset;
  assign bus.location       = r_location;
  assign bus.location_valid = r_valid;
  assign bus.new_location   = w_new_location;
  assign bus.ack_a          = w_ack_a;
  assign bus.ack_b          = w_ack_b;
  assign bus.scan_error     = w_scan_error;
  assign bus.state          = r_state;

endmodule
